rom_download_ctrl: RTL and testbench

//  Sits between hps_io's ioctl download port and crazy_climber's dn_* ROM-load port.

---
 rtl/rom_download_ctrl.sv | 163 ++++++++++++++++
 tb/tb_rom_download_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_ctrl.sv
// ROM download controller: registers the hps_io ioctl byte stream onto the core's dn_* port,
// tags each byte with its ROM region, and holds the core in reset until a full ROM set has loaded.
`timescale 1ns/1ps
module rom_download_ctrl #(
    parameter int unsigned ROM_SIZE    = 32'h10000,
    parameter logic [15:0] R1_BASE     = 16'h8000,
    parameter logic [15:0] R2_BASE     = 16'hA000,
    parameter logic [15:0] R3_BASE     = 16'hC000,
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [1:0]  rom_sel,
    output logic        core_reset,
    output logic        rom_loaded,
    output logic        dl_done,
    output logic        overflow,
    output logic [15:0] checksum,
    output logic [16:0] byte_count,
    output logic [4:0]  state_dbg
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    // One-hot so core_reset decodes from a single state bit.
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_LOAD  = 5'b00010,
        ST_FLUSH = 5'b00100,
        ST_HOLD  = 5'b01000,
        ST_DONE  = 5'b10000
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] hold_cnt;

    logic in_load;
    logic enter_load;
    logic hold_expire;
    logic wr_hit;
    logic in_range;
    logic accept;
    logic reject;

    function automatic logic [1:0] region_of(input logic [15:0] a);
        if (a >= R3_BASE)      return 2'd3;
        else if (a >= R2_BASE) return 2'd2;
        else if (a >= R1_BASE) return 2'd1;
        else                   return 2'd0;
    endfunction

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (ioctl_download) state_next = ST_LOAD;
            ST_LOAD:  if (!ioctl_download) state_next = ST_FLUSH;
            ST_FLUSH: state_next = ioctl_download ? ST_LOAD : ST_HOLD;
            ST_HOLD: begin
                if (ioctl_download)      state_next = ST_LOAD;
                else if (hold_cnt == '0) state_next = ST_DONE;
            end
            ST_DONE:  if (ioctl_download) state_next = ST_LOAD;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        core_reset  = (state != ST_DONE);
        in_load     = (state == ST_LOAD);
        enter_load  = (state != ST_LOAD) && (state_next == ST_LOAD);
        hold_expire = (state == ST_HOLD) && (state_next == ST_DONE);
        state_dbg   = state;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state == ST_FLUSH) begin
            hold_cnt <= HOLD_LOAD;
        end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rom_loaded <= 1'b0;
            dl_done    <= 1'b0;
        end else begin
            dl_done <= hold_expire;
            if (enter_load) begin
                rom_loaded <= 1'b0;
            end else if (hold_expire) begin
                rom_loaded <= 1'b1;
            end
        end
    end

    always_comb begin
        wr_hit   = ioctl_wr & ioctl_download & in_load;
        in_range = ({7'd0, ioctl_addr} < ROM_SIZE);
        accept   = wr_hit & in_range;
        reject   = wr_hit & ~in_range;
    end

    // dn_wr is a one-cycle strobe qualifying dn_addr/dn_data/rom_sel; there is no ready,
    // the core must take every strobe. The qualified fields hold between strobes.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dn_wr   <= 1'b0;
            dn_addr <= '0;
            dn_data <= '0;
            rom_sel <= '0;
        end else begin
            dn_wr <= accept;
            if (accept) begin
                dn_addr <= ioctl_addr[15:0];
                dn_data <= ioctl_dout;
                rom_sel <= region_of(ioctl_addr[15:0]);
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            checksum   <= '0;
            byte_count <= '0;
            overflow   <= 1'b0;
        end else if (enter_load) begin
            checksum   <= '0;
            byte_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept) begin
                checksum <= checksum + {8'd0, ioctl_dout};
                if (byte_count != 17'h1FFFF) begin
                    byte_count <= byte_count + 17'd1;
                end
            end
            if (reject) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Bench for rom_download_ctrl: queue-based scoreboard fed by a download-level reference model.
`timescale 1ns/1ps
module tb_rom_download_ctrl;

    localparam int H = 1024;
    localparam int W = 58;
    localparam logic [4:0] LOAD_CODE = 5'b00010;
    localparam logic [4:0] IDLE_CODE = 5'b00001;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [1:0]  rom_sel;
    logic        core_reset;
    logic        rom_loaded;
    logic        dl_done;
    logic        overflow;
    logic [15:0] checksum;
    logic [16:0] byte_count;
    logic [4:0]  state_dbg;

    rom_download_ctrl dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .rom_sel(rom_sel),
        .core_reset(core_reset), .rom_loaded(rom_loaded), .dl_done(dl_done),
        .overflow(overflow), .checksum(checksum), .byte_count(byte_count),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_sys = ~clk_sys;
    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // ---------------- model and scoreboard ----------------
    logic [W-1:0] exp_q[$];   // {rom_sel, addr, data, due cycle}
    int           done_q[$];  // due cycles of dl_done pulses
    logic [15:0]  m_sum = '0;
    int           m_count = 0;
    bit           m_ovf = 1'b0;
    bit           m_active = 1'b0;
    int           m_done_at = -1;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] e;
    int           d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] ref_region(input logic [24:0] a);
        if (a >= 25'hC000)      return 2'd3;
        else if (a >= 25'hA000) return 2'd2;
        else if (a >= 25'h8000) return 2'd1;
        else                    return 2'd0;
    endfunction

    function automatic bit exp_loaded();
        return (m_done_at >= 0) && (cyc >= m_done_at);
    endfunction

    always @(negedge clk_sys) begin
        if (dn_wr) begin
            if (exp_q.size() == 0) begin
                check("dn_wr_unexpected", 32'(dn_wr), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("dn_wr_cycle", cyc, e[31:0]);
                check("dn_addr", 32'(dn_addr), 32'(e[55:40]));
                check("dn_data", 32'(dn_data), 32'(e[39:32]));
                check("rom_sel", 32'(rom_sel), 32'(e[57:56]));
            end
        end
        if (dl_done) begin
            if (done_q.size() == 0) begin
                check("dl_done_unexpected", 32'(dl_done), 32'd0);
            end else begin
                d = done_q.pop_front();
                check("dl_done_cycle", cyc, d);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl(input bit wr_on_rise);
        ioctl_download = 1'b1;
        if (wr_on_rise) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'($urandom_range(0, 16'hFFFF));
            ioctl_dout = 8'($urandom);
        end
        while (done_q.size() > 0 && done_q[$] >= cyc + 1) void'(done_q.pop_back());
        m_done_at = -1;
        m_sum = '0;
        m_count = 0;
        m_ovf = 1'b0;
        tick();
        ioctl_wr = 1'b0;
        m_active = 1'b1;
    endtask

    task automatic write_byte(input logic [24:0] a, input logic [7:0] dv);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = dv;
        if (m_active && ioctl_download) begin
            if (a < 25'h10000) begin
                exp_q.push_back({ref_region(a), a[15:0], dv, 32'(cyc + 1)});
                m_sum = m_sum + 16'(dv);
                if (m_count < 'h1FFFF) m_count++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic end_dl(input bit wr_on_fall, output int flush_cyc);
        ioctl_download = 1'b0;
        m_active = 1'b0;
        if (wr_on_fall) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'($urandom_range(0, 16'hFFFF));
            ioctl_dout = 8'($urandom);
        end
        tick();
        ioctl_wr = 1'b0;
        flush_cyc = cyc;
        m_done_at = flush_cyc + 1 + H;
        done_q.push_back(m_done_at);
    endtask

    task automatic wait_done();
        while (cyc < m_done_at + 2) tick();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_checksum"}, 32'(checksum), 32'(m_sum));
        check({tag, "_byte_count"}, 32'(byte_count), 32'(m_count));
        check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_rom_loaded"}, 32'(rom_loaded), 32'(exp_loaded()));
        check({tag, "_core_reset"}, 32'(core_reset), 32'(!exp_loaded()));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dn_addr"}, 32'(dn_addr), 32'd0);
        check({tag, "_dn_data"}, 32'(dn_data), 32'd0);
        check({tag, "_dn_wr"}, 32'(dn_wr), 32'd0);
        check({tag, "_rom_sel"}, 32'(rom_sel), 32'd0);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_rom_loaded"}, 32'(rom_loaded), 32'd0);
        check({tag, "_dl_done"}, 32'(dl_done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_checksum"}, 32'(checksum), 32'd0);
        check({tag, "_byte_count"}, 32'(byte_count), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE_CODE));
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int f;
        logic [24:0] a;
        logic [24:0] five_addr[5];
        five_addr = '{25'h7FFF, 25'h8000, 25'hA000, 25'hC000, 25'hFFFF};

        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b0;

        // idle with stray writes that must be ignored
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 49) == 0) write_byte(25'($urandom_range(0, 16'hFFFF)), 8'($urandom));
            else tick();
        end
        check("idle_core_reset", 32'(core_reset), 32'd1);
        check("idle_rom_loaded", 32'(rom_loaded), 32'd0);

        // sequential 16-byte download
        start_dl(1'b1);
        for (int i = 0; i < 16; i++) write_byte(25'(i), 8'(i + 1));
        end_dl(1'b1, f);
        check("t2_checksum_const", 32'(checksum), 32'h0088);
        check("t2_count_const", 32'(byte_count), 32'd16);
        check_status("t2_hold");
        wait_done();
        check_status("t2_done");

        // region boundaries, back-to-back
        start_dl(1'b0);
        for (int i = 0; i < 5; i++) write_byte(five_addr[i], 8'($urandom));
        end_dl(1'b0, f);
        wait_done();
        check_status("t3_done");

        // out-of-range byte
        start_dl(1'b0);
        write_byte(25'h1234, 8'h5A);
        write_byte(25'h10000, 8'hAA);
        tick();
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_dn_addr_hold", 32'(dn_addr), 32'h1234);
        check_status("t4_load");
        write_byte(25'($urandom_range(25'h10000, 25'h1FFFFFF)), 8'($urandom));
        end_dl(1'b0, f);
        wait_done();
        check_status("t4_done");
        start_dl(1'b0);
        check("t4_overflow_cleared", 32'(overflow), 32'd0);

        // restart in the middle of HOLD
        for (int i = 0; i < 6; i++) write_byte(25'($urandom_range(0, 16'hFFFF)), 8'($urandom));
        end_dl(1'b0, f);
        while (cyc < f + 524) tick();
        start_dl(1'b0);
        check("t5_state_load", 32'(state_dbg), 32'(LOAD_CODE));
        check_status("t5_restart");
        for (int i = 0; i < 4; i++) write_byte(25'($urandom_range(0, 16'hFFFF)), 8'($urandom));
        end_dl(1'b0, f);
        wait_done();
        check_status("t5_done");

        // reset in the middle of LOAD
        start_dl(1'b0);
        for (int i = 0; i < 8; i++) write_byte(25'(16'h8000 + i), 8'($urandom));
        tick();
        reset = 1'b1;
        ioctl_download = 1'b0;
        #1;
        check_reset_vals("t6_async");
        m_active = 1'b0;
        m_done_at = -1;
        m_sum = '0;
        m_count = 0;
        m_ovf = 1'b0;
        exp_q.delete();
        done_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_status("t6_after");

        // randomized downloads
        for (int n = 0; n < 4; n++) begin
            start_dl(1'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(10, 40)); i++) begin
                repeat ($urandom_range(0, 2)) tick();
                if ($urandom_range(0, 7) == 0) a = 25'($urandom_range(25'h10000, 25'h1FFFFFF));
                else a = 25'($urandom_range(0, 16'hFFFF));
                write_byte(a, 8'($urandom));
            end
            tick();
            check_status("rnd_load");
            end_dl(1'($urandom_range(0, 1)), f);
            wait_done();
            check_status("rnd_done");
        end

        repeat (5) tick();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
